// File: rtl/alu_pkg.sv
// Shared op-codes, FSM state encoding and flag derivation for the sequential ALU.
package alu_pkg;

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_NOT  = 4'b0010;
   localparam logic [3:0] OP_NOR  = 4'b0011;
   localparam logic [3:0] OP_XOR  = 4'b0100;
   localparam logic [3:0] OP_NAND = 4'b0101;
   localparam logic [3:0] OP_ADD  = 4'b0110;
   localparam logic [3:0] OP_SUB  = 4'b0111;
   localparam logic [3:0] OP_MUL  = 4'b1000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic cout;
      logic negative;
      logic zero;
      logic overflow;
   } flags_t;

   // b_msb is the msb of the operand actually added (already inverted for SUB).
   function automatic flags_t calc_flags(input logic y_msb, input logic y_zero,
                                         input logic carry, input logic a_msb,
                                         input logic b_msb, input logic arith,
                                         input logic mul_ovf);
      flags_t f;
      f.cout     = carry;
      f.negative = y_msb;
      f.zero     = y_zero;
      f.overflow = (arith && (a_msb == b_msb) && (y_msb != a_msb)) || mul_ovf;
      return f;
   endfunction

endpackage

// File: rtl/seq_alu_mul.sv
// Iterative shift-add unsigned multiplier; one partial product per cycle over WIDTH cycles.
module seq_alu_mul
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);

   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               busy_q, busy_d;

   always_comb begin
      mcand_d  = mcand_q;
      prod_d   = prod_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      if (start) begin
         mcand_d  = {{WIDTH{1'b0}}, A};
         mplier_d = B;
         prod_d   = '0;
         cnt_d    = CNT_INIT;
         busy_d   = 1'b1;
      end else if (busy_q && (cnt_q != '0)) begin
         if (mplier_q[0]) begin
            prod_d = prod_q + mcand_q;
         end
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q - 1'b1;
         busy_d   = (cnt_q != CNT_W'(1));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mcand_q  <= '0;
         prod_q   <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
      end else begin
         mcand_q  <= mcand_d;
         prod_q   <= prod_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
      end
   end

   // The final product is offered on the edge the counter reaches zero, so the
   // caller registers it in the same edge rather than one cycle later.
   assign done    = busy_q && (cnt_q == CNT_W'(1));
   assign product = prod_d;
   assign busy    = busy_q;

endmodule

// File: rtl/seq_alu.sv
// Registered WIDTH-bit ALU with valid/ready handshakes; logic and add/sub are single-cycle, MUL is iterative.
module seq_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  A,
   input  logic [WIDTH-1:0]  B,
   input  logic [3:0]        sel,
   input  logic              Cin,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  Y,
   output logic              Cout,
   output logic              Negative,
   output logic              Zero,
   output logic              Overflow,
   output logic              Illegal
);

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   y_q, y_d;
   flags_t             flags_q, flags_d;
   logic               illegal_q, illegal_d;

   logic               mul_start, mul_busy, mul_done, mul_ovf;
   logic [2*WIDTH-1:0] mul_product;

   logic               sub_op, arith_op, carry_in;
   logic [WIDTH-1:0]   b_eff, op_y;
   logic [WIDTH:0]     sum;

   seq_alu_mul #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (mul_start),
      .A       (A),
      .B       (B),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (mul_product)
   );

   // SUB is A + ~B + 1, sharing the ADD carry chain.
   always_comb begin
      sub_op   = (sel == OP_SUB);
      arith_op = (sel == OP_ADD) || sub_op;
      b_eff    = sub_op ? ~B : B;
      carry_in = sub_op ? 1'b1 : Cin;
      sum      = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, carry_in};
      case (sel)
         OP_AND:  op_y = A & B;
         OP_OR:   op_y = A | B;
         OP_NOT:  op_y = ~A;
         OP_NOR:  op_y = ~(A | B);
         OP_XOR:  op_y = A ^ B;
         OP_NAND: op_y = ~(A & B);
         OP_ADD,
         OP_SUB:  op_y = sum[WIDTH-1:0];
         default: op_y = '0;
      endcase
   end

   assign mul_ovf = |mul_product[2*WIDTH-1:WIDTH];

   always_comb begin
      state_d   = state_q;
      y_d       = y_q;
      flags_d   = flags_q;
      illegal_d = illegal_q;
      mul_start = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid && in_ready) begin
               if (sel == OP_MUL) begin
                  mul_start = 1'b1;
                  state_d   = BUSY;
               end else begin
                  y_d       = op_y;
                  illegal_d = (sel > OP_MUL);
                  flags_d   = calc_flags(op_y[WIDTH-1], (op_y == '0), arith_op && sum[WIDTH],
                                         A[WIDTH-1], b_eff[WIDTH-1], arith_op, 1'b0);
                  state_d   = DONE;
               end
            end
         end
         BUSY: begin
            if (mul_done) begin
               y_d       = mul_product[WIDTH-1:0];
               illegal_d = 1'b0;
               flags_d   = calc_flags(mul_product[WIDTH-1], (mul_product[WIDTH-1:0] == '0),
                                      mul_ovf, 1'b0, 1'b0, 1'b0, mul_ovf);
               state_d   = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         y_q       <= '0;
         flags_q   <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         y_q       <= y_d;
         flags_q   <= flags_d;
         illegal_q <= illegal_d;
      end
   end

   assign in_ready  = (state_q == IDLE) && !mul_busy;
   assign out_valid = (state_q == DONE);
   assign Y         = y_q;
   assign Cout      = flags_q.cout;
   assign Negative  = flags_q.negative;
   assign Zero      = flags_q.zero;
   assign Overflow  = flags_q.overflow;
   assign Illegal   = illegal_q;

endmodule

// File: tb/tb_seq_alu.sv
// Randomised and directed bench for seq_alu against an arithmetic reference model.
module tb_seq_alu;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  A = '0;
   logic [W-1:0]  B = '0;
   logic [3:0]    sel = 4'd0;
   logic          Cin = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [W-1:0]  Y;
   logic          Cout, Negative, Zero, Overflow, Illegal;

   seq_alu #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .sel       (sel),
      .Cin       (Cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Y         (Y),
      .Cout      (Cout),
      .Negative  (Negative),
      .Zero      (Zero),
      .Overflow  (Overflow),
      .Illegal   (Illegal)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h cyc=%0d", name, act, exp, cyc);
      end
   endtask

   typedef struct {
      logic [W-1:0] y;
      bit cout, neg, zero, ovf, ill;
      int acc;
      int lat;
   } exp_t;

   exp_t q[$];
   bit   seen = 0;

   // Reference: plain wide arithmetic straight from the op definitions.
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [3:0] s, input logic cin);
      exp_t e;
      logic [W:0]     s33;
      logic [W-1:0]   nb;
      logic [2*W-1:0] p;
      e.y = '0; e.cout = 0; e.ovf = 0; e.ill = 0; e.acc = 0;
      case (s)
         4'd0: e.y = a & b;
         4'd1: e.y = a | b;
         4'd2: e.y = ~a;
         4'd3: e.y = ~(a | b);
         4'd4: e.y = a ^ b;
         4'd5: e.y = ~(a & b);
         4'd6: begin
            s33 = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
            e.y = s33[W-1:0];
            e.cout = s33[W];
            e.ovf = (a[W-1] == b[W-1]) && (e.y[W-1] != a[W-1]);
         end
         4'd7: begin
            nb = ~b;
            s33 = {1'b0, a} + {1'b0, nb} + (W+1)'(1);
            e.y = s33[W-1:0];
            e.cout = s33[W];
            e.ovf = (a[W-1] == nb[W-1]) && (e.y[W-1] != a[W-1]);
         end
         4'd8: begin
            p = (2*W)'(a) * (2*W)'(b);
            e.y = p[W-1:0];
            e.cout = (p[2*W-1:W] != '0);
            e.ovf = e.cout;
         end
         default: e.ill = 1;
      endcase
      e.neg  = e.y[W-1];
      e.zero = (e.y == '0);
      e.lat  = (s == 4'd8) ? W + 1 : 1;
      return e;
   endfunction

   logic [W-1:0] last_y;
   bit           last_cout, last_neg, last_zero, last_ovf, last_ill;
   int           last_lat = 0;
   int           delivered = 0;

   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid) begin
            chk("in_ready_in_done", in_ready, 0);
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output actual Y=%0h required no output cyc=%0d", Y, cyc);
            end else begin
               chk("Y", Y, q[0].y);
               chk("Cout", Cout, q[0].cout);
               chk("Negative", Negative, q[0].neg);
               chk("Zero", Zero, q[0].zero);
               chk("Overflow", Overflow, q[0].ovf);
               chk("Illegal", Illegal, q[0].ill);
               if (!seen) begin
                  last_lat = cyc - q[0].acc;
                  chk("latency", last_lat, q[0].lat);
                  seen = 1;
               end
               if (out_ready) begin
                  last_y = Y; last_cout = Cout; last_neg = Negative;
                  last_zero = Zero; last_ovf = Overflow; last_ill = Illegal;
                  delivered++;
                  void'(q.pop_front());
                  seen = 0;
               end
            end
         end else if (q.size() > 0 && !seen && (cyc - q[0].acc) > W + 10) begin
            checks++;
            errors++;
            $display("FAIL result_timeout actual no out_valid after %0d cycles required %0d", cyc - q[0].acc, q[0].lat);
            void'(q.pop_front());
         end
      end
   end

   int ready_mode = 0;
   initial forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 1) out_ready = 1'($urandom_range(0, 1));
   end

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [3:0] s, input logic c);
      exp_t e;
      int n = 0;
      while (!in_ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) begin
         chk("in_ready_wait", in_ready, 1);
         return;
      end
      A = a; B = b; sel = s; Cin = c; in_valid = 1'b1;
      e = model(a, b, s, c);
      e.acc = cyc;
      q.push_back(e);
      @(posedge clk); #1;
      in_valid = 1'b0;
      A = $urandom; B = $urandom; sel = 4'($urandom); Cin = 1'($urandom);
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() > 0 && n < W + 40) begin
         @(posedge clk); #1;
         n++;
      end
      if (q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout actual %0d pending required 0", q.size());
         q.delete();
         seen = 0;
      end
   endtask

   initial begin
      int d0;
      logic [W-1:0] ra, rb;
      logic [3:0]   rs;

      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_Y", Y, 0);
      chk("rst_flags", {Cout, Negative, Zero, Overflow, Illegal}, 5'b0);

      send(32'h7FFF_FFFF, 32'h1, 4'd6, 1'b0);
      drain();
      chk("add_Y", last_y, 32'h8000_0000);
      chk("add_NCZV", {last_neg, last_cout, last_zero, last_ovf}, 4'b1001);
      chk("add_in_ready", in_ready, 1);

      send(32'd5, 32'd5, 4'd7, 1'b1);
      drain();
      chk("sub_eq_Y", last_y, 0);
      chk("sub_eq_ZCV", {last_zero, last_cout, last_ovf}, 3'b110);
      send(32'd0, 32'd1, 4'd7, 1'b0);
      drain();
      chk("sub_neg_Y", last_y, 32'hFFFF_FFFF);
      chk("sub_neg_CN", {last_cout, last_neg}, 2'b01);

      for (int s = 0; s < 6; s++) begin
         send(32'hF0F0_1234, 32'h0FF0_FFFF, 4'(s), 1'b1);
         drain();
         if (s == 5) chk("nand_Y", last_y, 32'hFF0F_EDCB);
         if (s == 2) chk("not_Y", last_y, 32'h0F0F_EDCB);
      end

      send(32'h0001_0000, 32'h0001_0000, 4'd8, 1'b0);
      drain();
      chk("mul_big_lat", last_lat, 33);
      chk("mul_big_Y", last_y, 0);
      chk("mul_big_ZCV", {last_zero, last_cout, last_ovf}, 3'b111);
      send(32'd1234, 32'd5678, 4'd8, 1'b0);
      drain();
      chk("mul_small_Y", last_y, 32'd7006652);
      chk("mul_small_C", last_cout, 0);
      send($urandom, 32'd0, 4'd8, 1'b0);
      drain();
      chk("mul_b0_lat", last_lat, 33);
      send(32'd0, $urandom, 4'd8, 1'b0);
      drain();
      chk("mul_a0_Z", last_zero, 1);

      out_ready = 1'b0;
      send(32'd3, 32'd4, 4'd6, 1'b0);
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1; A = $urandom; B = $urandom; sel = 4'd6;
         @(posedge clk); #1;
         chk("stall_Y", Y, 7);
         chk("stall_valid_ready", {out_valid, in_ready}, 2'b10);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      drain();
      chk("stall_release_in_ready", in_ready, 1);
      repeat (5) @(posedge clk);
      #1;

      send(32'h1234, 32'h5678, 4'b1010, 1'b0);
      drain();
      chk("illegal_YIZ", {last_y, last_ill, last_zero}, {32'h0, 1'b1, 1'b1});

      d0 = delivered;
      send($urandom, $urandom, 4'd8, 1'b0);
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      q.delete();
      seen = 0;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midrst_ready_valid", {in_ready, out_valid}, 2'b10);
      chk("midrst_Y_flags", {Y, Illegal, Zero}, {32'h0, 1'b0, 1'b0});
      repeat (W + 10) @(posedge clk);
      #1;
      chk("midrst_no_delivery", delivered, d0);

      ready_mode = 1;
      for (int i = 0; i < 80; i++) begin
         rs = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 2) == 0) rs = 4'd8;
         ra = $urandom;
         rb = $urandom;
         if ($urandom_range(0, 1) == 1) begin
            ra = ra & 32'h0000_FFFF;
            rb = rb & 32'h0000_FFFF;
         end
         send(ra, rb, rs, 1'($urandom));
      end
      ready_mode = 0;
      out_ready = 1'b1;
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Registered, parametrised-width ALU with valid/ready handshakes on input and output.
- Keeps the existing single-bit logic op encoding and extends it to full WIDTH.
- Adds ADD/SUB with full flags and an iterative shift-add multiply that takes several cycles.
- Sits between the operand register stage and the writeback stage of the datapath.

Parameters:
- WIDTH, 32, operand/result width in bits (>=2).
- CNT_W, $clog2(WIDTH)+1, width of the multiply iteration counter (derived; do not override).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operands and op are presented.
- in_ready  out  1  block can accept an operation.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- sel  in  4  operation select.
- Cin  in  1  carry in; used by ADD only.
- out_valid  out  1  result and flags are valid.
- out_ready  in  1  consumer accepts the result.
- Y  out  WIDTH  result.
- Cout  out  1  carry/overflow-of-product flag.
- Negative  out  1  Y[WIDTH-1].
- Zero  out  1  Y==0.
- Overflow  out  1  signed overflow.
- Illegal  out  1  sel was an unsupported encoding.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state=IDLE, in_ready=1, out_valid=0, Y=0, Cout=0, Negative=0, Zero=0, Overflow=0, Illegal=0, counter=0.
- Reset mid-operation: rst wins over all other events. A multiply in BUSY or a result in DONE is discarded, with no output handshake.
- sel encoding (bitwise over WIDTH):
  - 0000 AND, 0001 OR, 0010 NOT A, 0011 NOR, 0100 XOR, 0101 NAND.
  - 0110 ADD: Y = A+B+Cin.
  - 0111 SUB: Y = A+~B+1; Cin is ignored.
  - 1000 MUL: Y = low WIDTH bits of A*B, unsigned.
  - 1001-1111 are illegal.
- Flags:
  - Logic ops: Cout=0, Overflow=0.
  - ADD/SUB: Cout = carry out of bit WIDTH-1 (SUB: 1 means no borrow). Overflow = (A[msb]==B'[msb]) && (Y[msb]!=A[msb]), where B' = B for ADD and ~B for SUB.
  - MUL: Cout = Overflow = (upper WIDTH bits of the 2*WIDTH product != 0).
  - Illegal sel: Y=0, Illegal=1, Cout=0, Overflow=0; Zero and Negative still follow Y, so Zero=1, Negative=0.
  - Negative and Zero always track the registered Y.
- FSM states IDLE, BUSY, DONE:
  - IDLE: in_ready=1. An accept is in_valid&&in_ready at a clock edge, and all inputs are captured then.
  - IDLE, non-MUL accepted: result and flags are registered at that edge and the FSM goes to DONE. out_valid is high in the following cycle (latency 1).
  - IDLE, MUL accepted: capture A as the multiplicand (left-shifting), B as the multiplier (right-shifting), product=0, counter=WIDTH. Go to BUSY.
  - BUSY: in_ready=0. Each cycle: if multiplier[0], product += multiplicand. Then shift, decrement counter. On the edge where counter reaches 0, register Y and flags and go to DONE.
  - MUL latency: out_valid is high WIDTH+1 cycles after the accept edge. The operand path is fully 2*WIDTH-bit, so no truncation happens before the flags are computed.
  - DONE: in_ready=0. Y and all flags are held stable while out_valid=1 and out_ready=0, and they remain stable through any number of stall cycles. On out_valid&&out_ready, go to IDLE with out_valid=0.
  - No overlap between result and new input: peak throughput is one op per 2 cycles.
- Input changes: in_valid or operand changes while in_ready=0 are ignored and have no effect.
- out_ready already high on entry to DONE: the handoff happens in the first DONE cycle.
- MUL boundaries: multiplier B=0 still takes the full WIDTH cycles (fixed latency). A=0 gives Y=0, Zero=1.

Decomposition:
- Package alu_pkg holds:
  - The sel op-code localparams (OP_AND … OP_MUL).
  - The state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2).
  - A function that computes the flags from Y, the carry and the operand msbs.
- Sub-module seq_alu_mul: the iterative shift-add datapath. Ports: clk, rst, start, A, B, busy, done, product[2*WIDTH-1:0].
- Logic ops and ADD/SUB stay inline in seq_alu.

Test Plan:
- Reset, then ADD with WIDTH=32, A=32'h7FFF_FFFF, B=1, Cin=0, out_ready=1 -> one cycle later out_valid=1, Y=32'h8000_0000, Negative=1, Overflow=1, Cout=0, Zero=0; then in_ready returns to 1.
- SUB with A=5, B=5 -> Y=0, Zero=1, Cout=1, Overflow=0. Then SUB with A=0, B=1 -> Y=32'hFFFF_FFFF, Cout=0, Negative=1.
- All six logic ops on A=32'hF0F0_1234, B=32'h0FF0_FFFF, checked against a bitwise model. For example NAND -> Y=32'hFF0F_EDCB; NOT -> Y=32'h0F0F_EDCB; Cout=0 and Overflow=0 for every logic op.
- MUL with A=32'h0001_0000, B=32'h0001_0000 -> out_valid exactly 33 cycles after accept, Y=0, Zero=1, Cout=1, Overflow=1. MUL with A=1234, B=5678 -> Y=7006652, Cout=0.
- Output stall: hold out_ready=0 for 10 cycles after ADD A=3, B=4 -> Y stays 7 with out_valid=1 and in_ready=0 throughout, and a concurrent in_valid is ignored. Release out_ready -> handoff, then IDLE.
- Illegal sel=4'b1010 -> Y=0, Illegal=1, Zero=1. Then assert rst during a MUL at cycle 10 of BUSY -> next cycle IDLE, out_valid=0, in_ready=1, and no result is ever delivered.
